// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared constants for the synch_fifo read-side drainer:
//   FIFO_WIDTH_DEF            default data width (must match synch_fifo)
//   BUF_DEPTH_DEF/MIN/MAX     local buffer depth default and legal range
//   CNT_W_DEF                 default width of the occupancy count
//   cnt_w_for()               smallest width w with 2**w > depth
// -----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

  localparam int FIFO_WIDTH_DEF = 32;
  localparam int BUF_DEPTH_DEF  = 3;
  localparam int BUF_DEPTH_MIN  = 2;
  localparam int BUF_DEPTH_MAX  = 8;
  localparam int CNT_W_DEF      = 4;

  // Width able to hold the values 0..depth.
  function automatic int cnt_w_for(input int depth);
    int w;
    w = 1;
    while ((1 << w) <= depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Valid/ready stream carrying words drained from synch_fifo.
//   m_valid  word present on m_data        (master -> slave)
//   m_data   stream word, FIFO_WIDTH bits  (master -> slave)
//   m_ready  consumer accepts this cycle   (slave  -> master)
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
);

  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid_buf
// Small circular buffer that absorbs words arriving from synch_fifo while the
// consumer stalls. Pointers wrap modulo BUF_DEPTH (any value, not only powers
// of two).
// Ports:
//   fifo_clk, rst   clock and asynchronous active-low reset
//   push, push_data write push_data at the tail (caller never pushes when full)
//   pop             remove the head (ignored when empty)
//   head_data       current head word, 0 when empty
//   cnt             number of words held, 0..BUF_DEPTH
// -----------------------------------------------------------------------------
module fifo_rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  fifo_clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [FIFO_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      cnt
);

  localparam int               PTR_W    = cnt_w_for(BUF_DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  pop_ok;
  logic [CNT_W-1:0]      cnt_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && (cnt != '0);

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_nxt; a missing
    // default would infer a latch.
    cnt_nxt = cnt;
    if (push && !pop_ok) begin
      cnt_nxt = cnt + 1'b1;
    end else if (!push && pop_ok) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt_nxt;
    end
  end

  // NOTE: storage has no reset; an entry is only observable after it has been
  // written, because head_data is forced to 0 while cnt is 0.
  always_ff @(posedge fifo_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = (cnt != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Drains synch_fifo (one-cycle registered read latency) and re-presents the
// words as a valid/ready stream. Reads are only issued when the local buffer
// has room for every word already requested, so the consumer may stall at
// any time. fifo_rden depends on registers and fifo_empty only, never on
// m_ready.
// Ports:
//   fifo_clk     clock, rising edge
//   rst          asynchronous active-low reset (shared with synch_fifo)
//   drain_en     allow new FIFO reads
//   fifo_empty   synch_fifo empty flag
//   fifo_rddata  synch_fifo read data, valid the cycle after fifo_rden
//   fifo_rden    read strobe to synch_fifo
//   m_if         stream master (m_valid, m_data out; m_ready in)
//   buf_level    local buffer occupancy
// Optional (`define FIFO_RD_STATS_EN):
//   stat_words   handshake count, wraps modulo 2^32
//   stat_stall   cycles with m_valid && !m_ready, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  fifo_clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rden,
  fifo_rd_stream_if.master      m_if,
  output logic [CNT_W-1:0]      buf_level
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [15:0]           stat_stall
`endif
);

  logic             inflight;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   committed;
  logic             pop;

  // Words already owned by this block: buffered plus the one on its way.
  assign committed = {1'b0, cnt} + (CNT_W + 1)'(inflight);

  // rst gating keeps the strobe low while reset is held, even with data
  // waiting and drain_en high.
  assign fifo_rden = rst && drain_en && !fifo_empty
                     && (committed < (CNT_W + 1)'(BUF_DEPTH));

  // The word requested last cycle is on fifo_rddata now.
  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst) inflight <= 1'b0;
    else      inflight <= fifo_rden;
  end

  assign m_if.m_valid = (cnt != '0);
  assign pop          = m_if.m_valid && m_if.m_ready;
  assign buf_level    = cnt;

  fifo_rd_skid_buf #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .CNT_W      (CNT_W)
  ) u_skid (
    .fifo_clk  (fifo_clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rddata),
    .pop       (pop),
    .head_data (m_if.m_data),
    .cnt       (cnt)
  );

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (pop) stat_words <= stat_words + 1'b1;
      if (m_if.m_valid && !m_if.m_ready && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Bench for fifo_rd_stream with a behavioural synch_fifo (array + counts,
// one-cycle registered read) and a scoreboard expecting every word written
// to the FIFO to appear on the stream exactly once, in order.
// Build with +define+FIFO_RD_STATS_EN to also check the statistics ports.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_rd_stream;

  localparam int W = 32;

  logic         fifo_clk = 1'b0;
  logic         rst = 1'b0;
  logic         drain_en = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_rddata = '0;
  logic         fifo_rden;
  logic [3:0]   buf_level;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]  stat_words;
  logic [15:0]  stat_stall;
`endif

  fifo_rd_stream_if #(.FIFO_WIDTH(W)) m_if ();

  fifo_rd_stream #(.FIFO_WIDTH(W), .BUF_DEPTH(3), .CNT_W(4)) dut (
    .fifo_clk    (fifo_clk),
    .rst         (rst),
    .drain_en    (drain_en),
    .fifo_empty  (fifo_empty),
    .fifo_rddata (fifo_rddata),
    .fifo_rden   (fifo_rden),
    .m_if        (m_if),
    .buf_level   (buf_level)
`ifdef FIFO_RD_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 fifo_clk = ~fifo_clk;

  // Behavioural synch_fifo: fmem holds every word ever written, in order.
  logic [W-1:0] fmem [0:4095];
  int wcnt = 0;
  int rcnt = 0;
  assign fifo_empty = (wcnt == rcnt);

  always @(posedge fifo_clk or negedge rst) begin
    if (!rst) begin
      rcnt        <= wcnt;
      fifo_rddata <= '0;
    end else if (fifo_rden) begin
      fifo_rddata <= fmem[rcnt];
      rcnt        <= rcnt + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int sb_rd = 0;
  int rden_total = 0;
  int hs_total = 0;
  int stall_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and invariants, evaluated once per cycle just before the edge.
  task automatic sample();
    if (!rst) begin
      sb_rd = wcnt;
      rden_total = 0;
      hs_total = 0;
      stall_total = 0;
      return;
    end
`ifdef FIFO_RD_STATS_EN
    check("stat_words", stat_words, hs_total);
    check("stat_stall", stat_stall, stall_total);
`endif
    check("no_underflow", fifo_rden && fifo_empty, 0);
    check("valid_iff_level", m_if.m_valid, buf_level != 0);
    if (!m_if.m_valid) check("idle_data_zero", m_if.m_data, 0);
    if (fifo_rden) rden_total++;
    if (m_if.m_valid && m_if.m_ready) begin
      check("sb_has_word", sb_rd < wcnt, 1);
      if (sb_rd < wcnt) check("sb_data", m_if.m_data, fmem[sb_rd]);
      sb_rd++;
      hs_total++;
    end
    if (m_if.m_valid && !m_if.m_ready && stall_total < 65535) stall_total++;
    check("owned_le_depth", (rden_total - hs_total) <= 3, 1);
    check("level_le_depth", buf_level <= 3, 1);
  endtask

  task automatic cyc(input logic de, input logic mr, input logic do_push, input logic [W-1:0] pdata);
    @(negedge fifo_clk);
    drain_en = de;
    m_if.m_ready = mr;
    if (do_push) begin
      fmem[wcnt] = pdata;
      wcnt++;
    end
    #2;
    sample();
  endtask

  typedef struct {
    logic         de;
    logic         mr;
    logic         rden;
    logic         valid;
    logic [W-1:0] data;
    logic [3:0]   level;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int rd0;
    int hs0;
    logic [W-1:0] w1;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         4'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         4'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_0001, 4'd1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_0002, 4'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_0003, 4'd1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hAAAA_0004, 4'd1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hAAAA_0005, 4'd1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0};

    m_if.m_ready = 1'b1;

    // Reset held for 100 ns with drain enabled and the FIFO empty.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      check("rst_rden", fifo_rden, 0);
      check("rst_valid", m_if.m_valid, 0);
      check("rst_level", buf_level, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      check("idle_rden", fifo_rden, 0);
      check("idle_valid", m_if.m_valid, 0);
      check("idle_level", buf_level, 0);
    end

    // Preload A..E, then drain at full rate via the vector table.
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 1'b1, 32'hAAAA_0000 + W'(i));
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].de, vecs[i].mr, 1'b0, '0);
      check($sformatf("vec%0d_rden", i), fifo_rden, vecs[i].rden);
      check($sformatf("vec%0d_valid", i), m_if.m_valid, vecs[i].valid);
      check($sformatf("vec%0d_data", i), m_if.m_data, vecs[i].data);
      check($sformatf("vec%0d_level", i), buf_level, vecs[i].level);
    end

    // Backpressure: 8 words, consumer stalled.
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, 32'hBB00_0000 + W'(i));
    w1 = 32'hBB00_0001;
    rd0 = rden_total;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, '0);
      if (i >= 2) check("stall_hold", m_if.m_data, w1);
    end
    check("bp_level", buf_level, 3);
    check("bp_rden_off", fifo_rden, 0);
    check("bp_reads", rden_total - rd0, 3);
    hs0 = hs_total;
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, '0);
    check("bp_delivered", hs_total - hs0, 8);
    check("bp_sb_done", sb_rd, wcnt);

    // drain_en drops right after a read is issued.
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 1'b1, 32'hCC00_0000 + W'(i));
    rd0 = rden_total;
    hs0 = hs_total;
    cyc(1'b1, 1'b1, 1'b0, '0);
    check("drop_first_rden", fifo_rden, 1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("drop_rden_off", fifo_rden, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    check("drop_reads", rden_total - rd0, 1);
    check("drop_words", hs_total - hs0, 1);
    check("drop_level", buf_level, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, '0);
    check("resume_words", hs_total - hs0, 4);
    check("resume_sb_done", sb_rd, wcnt);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 4, $urandom);
    end
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 1'b0, '0);
    check("rand_sb_done", sb_rd, wcnt);
    check("rand_fifo_empty", fifo_empty, 1);
    check("rand_level", buf_level, 0);

    // Mid-operation reset with two words buffered and one in flight.
    for (int i = 1; i <= 6; i++) cyc(1'b0, 1'b0, 1'b1, 32'hDD00_0000 + W'(i));
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    @(posedge fifo_clk);
    #1;
    check("pre_rst_level", buf_level, 2);
    check("pre_rst_valid", m_if.m_valid, 1);
    rst = 1'b0;
    #1;
    check("arst_rden", fifo_rden, 0);
    check("arst_valid", m_if.m_valid, 0);
    check("arst_data", m_if.m_data, 0);
    check("arst_level", buf_level, 0);
`ifdef FIFO_RD_STATS_EN
    check("arst_stat_words", stat_words, 0);
    check("arst_stat_stall", stat_stall, 0);
`else
    // No statistics ports in this build.
`endif
    cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      check("post_rst_valid", m_if.m_valid, 0);
    end
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b1, 1'b1, 32'hEE00_0000 + W'(i));
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, '0);
    check("post_rst_sb_done", sb_rd, wcnt);
    check("post_rst_words", hs_total, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side drainer for synch_fifo: issues fifo_rden against the FIFO's one-cycle registered read latency and re-presents the words as a valid/ready stream. Sits between synch_fifo's read port and any downstream consumer. A small local buffer absorbs in-flight reads, so the consumer can stall at any time without losing data. Full throughput is one word per cycle, with no combinational path from m_ready to fifo_rden.

Parameters:
FIFO_WIDTH, 32, data width; must match synch_fifo.
BUF_DEPTH, 3, local buffer entries; legal range 2..8. 3 or more gives 1 word/cycle; 2 gives 1 word per 2 cycles.
CNT_W, 4, width of buf_level; must satisfy 2^CNT_W > BUF_DEPTH.

Ports:
fifo_clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-low reset.
drain_en  input  1  when 1, the block may issue new FIFO reads.
fifo_empty  input  1  from synch_fifo.
fifo_rddata  input  FIFO_WIDTH  from synch_fifo; valid the cycle after fifo_rden.
fifo_rden  output  1  read strobe to synch_fifo.
m_valid  output  1  stream word valid.
m_ready  input  1  downstream accept.
m_data  output  FIFO_WIDTH  stream word; equals the buffer head.
buf_level  output  CNT_W  local buffer occupancy.

Behaviour:
- Reset (rst=0, async): fifo_rden=0, m_valid=0, m_data=0, buf_level=0, in-flight flag=0, pointers=0. No read is pending after reset; any read in flight is discarded, because synch_fifo shares the same rst.
- State:
  - cnt: 0..BUF_DEPTH.
  - inflight: 1 bit, set in the cycle after fifo_rden=1.
  - Circular buffer with wr_ptr and rd_ptr that wrap at BUF_DEPTH.
- Read issue (combinational from registers and fifo_empty only): fifo_rden = drain_en && !fifo_empty && (cnt + inflight < BUF_DEPTH).
- Capture: when inflight=1 at a rising edge, write fifo_rddata at wr_ptr; cnt increments and wr_ptr advances.
- Invariant: cnt + inflight <= BUF_DEPTH at all times, so a capture can never overflow the buffer.
- Output: m_valid = (cnt != 0). m_data = buf[rd_ptr], and reads 0 when cnt=0.
- Pop: an m_valid && m_ready handshake pops the head; rd_ptr advances and cnt decrements.
- Capture and pop in the same cycle: cnt is unchanged and both pointers advance.
- Latency: the first word reaches m_valid=1 two cycles after the fifo_rden cycle (rden at cycle N, capture at edge N+1, m_valid high in cycle N+2).
- Stall hold: while m_valid=1 and m_ready=0, m_data is held stable.
- drain_en falls with inflight=1: the pending word is still captured and presented. No new rden is issued.
- FIFO underflow protection: fifo_rden is never asserted while fifo_empty=1, regardless of drain_en.
- buf_level = cnt, registered.
- Pointer wrap: modulo BUF_DEPTH, including non-power-of-two values.

Optional Feature:
FIFO_RD_STATS_EN
- Defined: adds ports stat_words (output, 32 bits) and stat_stall (output, 16 bits).
  - stat_words counts m_valid && m_ready handshakes and wraps modulo 2^32.
  - stat_stall counts cycles with m_valid && !m_ready and saturates at 16'hFFFF.
  - Both reset to 0 on rst.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package or include holds:
  - FIFO_WIDTH default.
  - BUF_DEPTH default and legal range.
  - A constant function computing CNT_W from BUF_DEPTH.
- Sub-module fifo_rd_skid_buf holds the circular buffer, pointers and cnt, with a push/pop interface.
- fifo_rd_stream holds issue logic, the inflight flag and the optional stats.

Test Plan:
- Reset then idle: rst low for 100 ns, FIFO empty. fifo_rden=0, m_valid=0, buf_level=0 throughout.
- Preload and drain: FIFO holds 5 words A..E, drain_en=1, m_ready=1.
  - First rden is followed two cycles later by m_valid with m_data=A.
  - A..E come out in order on 5 consecutive cycles; the FIFO reaches fifo_empty=1 and fifo_rden then stays 0.
- Backpressure: FIFO holds 8 words, m_ready=0.
  - buf_level settles at 3, and fifo_rden stops after 3 reads.
  - Raising m_ready then delivers words 1..8 in order with no loss or duplication.
- drain_en drop: deassert drain_en in the cycle fifo_rden=1.
  - Exactly that word is still captured; no further rden is issued.
  - Re-enabling resumes with the next word.
- Random m_ready and random FIFO writes over 500 cycles, checked against a scoreboard:
  - no word lost or duplicated;
  - fifo_rden never high while fifo_empty=1;
  - cnt+inflight never exceeds 3.
- Mid-operation reset: assert rst with buf_level=2 and inflight=1. All outputs are 0 immediately (asynchronously), and stats are 0 when FIFO_RD_STATS_EN is defined.
